// File: rtl/sar_adc_pkg.sv
// rtl/sar_adc_pkg.sv - shared types and constants for the SAR ADC controller
package sar_adc_pkg;

  localparam int DATA_W_DEF = 8;

  localparam logic [DATA_W_DEF-1:0] TRIAL_MSB = {1'b1, {(DATA_W_DEF-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DECIDE = 2'd2
  } sar_state_t;

endpackage

// File: rtl/sar_adc_ctrl_cdc_sync.sv
// rtl/sar_adc_ctrl_cdc_sync.sv - multi-stage single-bit synchroniser
module cdc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/sar_adc_ctrl.sv
// rtl/sar_adc_ctrl.sv - successive-approximation ADC controller driving an R-2R DAC
import sar_adc_pkg::*;

module sar_adc_ctrl #(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int SETTLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic              cont,
  input  logic              cmp_in,
  output logic [DATA_W-1:0] dac_bin,
  output logic              busy,
  output logic [DATA_W-1:0] result,
  output logic              result_valid,
  output logic [DATA_W-1:0] led
);

  localparam int L_IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int L_CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [DATA_W-1:0]  L_MSB      = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [L_IDX_W-1:0] L_IDX_TOP  = L_IDX_W'(DATA_W - 1);
  localparam logic [L_CNT_W-1:0] L_CNT_LOAD = L_CNT_W'(SETTLE_CYCLES - 1);

  sar_state_t         r_state;
  sar_state_t         w_state_nxt;
  logic [DATA_W-1:0]  r_trial;
  logic [DATA_W-1:0]  w_trial_dec;
  logic [L_IDX_W-1:0] r_bit_idx;
  logic [L_CNT_W-1:0] r_cnt;
  logic [DATA_W-1:0]  r_result;
  logic               r_busy;
  logic               r_valid;
  logic               w_cmp_s;
  logic               w_load;
  logic               w_decide;
  logic               w_last;

  cdc_sync #(
    .STAGES (SYNC_STAGES)
  ) u_cmp_sync (
    .clk  (clk),
    .rstn (rstn),
    .i_d  (cmp_in),
    .o_q  (w_cmp_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and the control strobes that steer the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_decide    = 1'b0;
    w_last      = 1'b0;
    case (r_state)
      IDLE: begin
        if (start || cont) begin
          w_state_nxt = SETTLE;
          w_load      = 1'b1;
        end
      end
      SETTLE: begin
        if (r_cnt == '0) begin
          w_state_nxt = DECIDE;
        end
      end
      DECIDE: begin
        w_decide = 1'b1;
        if (r_bit_idx == '0) begin
          w_state_nxt = IDLE;
          w_last      = 1'b1;
        end else begin
          w_state_nxt = SETTLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Resolve the current bit from the comparator and seed the next trial bit.
  always_comb begin
    w_trial_dec = r_trial;
    if (!w_cmp_s) begin
      w_trial_dec[r_bit_idx] = 1'b0;
    end
    if (r_bit_idx != '0) begin
      w_trial_dec[r_bit_idx - L_IDX_W'(1)] = 1'b1;
    end
  end

  // Datapath: trial code, bit index, settle counter, result and status flags.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_trial   <= '0;
      r_bit_idx <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_busy    <= 1'b0;
      r_valid   <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_load) begin
        r_trial   <= L_MSB;
        r_bit_idx <= L_IDX_TOP;
        r_cnt     <= L_CNT_LOAD;
        r_busy    <= 1'b1;
      end else if (r_state == SETTLE) begin
        r_cnt <= r_cnt - L_CNT_W'(1);
      end else if (w_decide) begin
        r_trial <= w_trial_dec;
        if (w_last) begin
          r_result <= w_trial_dec;
          r_valid  <= 1'b1;
          r_busy   <= 1'b0;
        end else begin
          r_bit_idx <= r_bit_idx - L_IDX_W'(1);
          r_cnt     <= L_CNT_LOAD;
        end
      end
    end
  end

  // The DAC is parked at zero whenever no conversion is running.
  assign dac_bin      = (r_state == IDLE) ? '0 : r_trial;
  assign busy         = r_busy;
  assign result       = r_result;
  assign result_valid = r_valid;
  assign led          = r_result;

endmodule

// File: tb/tb_sar_adc_ctrl.sv
// tb/tb_sar_adc_ctrl.sv - self-checking bench for sar_adc_ctrl
module tb_sar_adc_ctrl;

  localparam int DATA_W  = 8;
  localparam int SETTLE  = 16;
  localparam int STEP    = SETTLE + 1;
  localparam int LAT     = DATA_W * STEP;
  localparam int PERIOD  = LAT + 1;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic              cont = 1'b0;
  logic              cmp_in = 1'b0;
  logic [DATA_W-1:0] dac_bin;
  logic              busy;
  logic [DATA_W-1:0] result;
  logic              result_valid;
  logic [DATA_W-1:0] led;

  logic [DATA_W-1:0] vin_code = '0;
  logic              cmp_pipe = 1'b0;

  int checks = 0;
  int errors = 0;

  sar_adc_ctrl #(
    .DATA_W        (DATA_W),
    .SETTLE_CYCLES (SETTLE),
    .SYNC_STAGES   (2)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .cont         (cont),
    .cmp_in       (cmp_in),
    .dac_bin      (dac_bin),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .led          (led)
  );

  always #5 clk = ~clk;

  // Ideal comparator with one cycle of response delay.
  always @(negedge clk) begin
    cmp_in   = cmp_pipe;
    cmp_pipe = (vin_code >= dac_bin);
  end

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (dac_bin !== 8'h00) begin errors++; $display("FAIL reset_dac_bin got %h exp 00", dac_bin); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL reset_result got %h exp 00", result); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", result_valid); end
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL reset_led got %h exp 00", led); end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  // One start-triggered conversion, checked cycle by cycle against a binary search
  // over the ideal transfer function. start_at >= 0 pulses start again mid-conversion.
  task automatic run_conv(input logic [7:0] vin, input int start_at, input string name);
    logic [7:0] seq [DATA_W];
    int code;
    int t;
    int nvalid;
    int vcyc;
    logic [7:0] exp_dac;
    logic       exp_busy;
    code = 0;
    for (int b = DATA_W - 1; b >= 0; b--) begin
      t = code + (1 << b);
      seq[DATA_W - 1 - b] = t[7:0];
      if (int'(vin) >= t) code = t;
    end
    vin_code = vin;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    nvalid = 0;
    vcyc = -1;
    for (int k = 0; k < LAT + 20; k++) begin
      exp_dac  = (k < LAT) ? seq[k / STEP] : 8'h00;
      exp_busy = (k < LAT);
      checks++; if (dac_bin !== exp_dac) begin errors++; $display("FAIL %s_dac_bin cyc %0d got %h exp %h", name, k, dac_bin, exp_dac); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL %s_busy cyc %0d got %b exp %b", name, k, busy, exp_busy); end
      if (result_valid === 1'b1) begin
        nvalid++;
        vcyc = k;
        checks++; if (result !== vin) begin errors++; $display("FAIL %s_result got %h exp %h", name, result, vin); end
        checks++; if (led !== vin) begin errors++; $display("FAIL %s_led got %h exp %h", name, led, vin); end
      end
      start = (k == start_at);
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (nvalid !== 1) begin errors++; $display("FAIL %s_valid_count got %0d exp 1", name, nvalid); end
    checks++; if (vcyc !== LAT) begin errors++; $display("FAIL %s_latency got %0d exp %0d", name, vcyc, LAT); end
    checks++; if (result !== vin) begin errors++; $display("FAIL %s_result_hold got %h exp %h", name, result, vin); end
  endtask

  task automatic test_single();
    run_conv(8'hA5, -1, "single_a5");
  endtask

  task automatic test_boundaries();
    run_conv(8'h00, -1, "vin_00");
    run_conv(8'hFF, -1, "vin_ff");
    run_conv(8'h80, -1, "vin_80");
  endtask

  task automatic test_random();
    logic [7:0] v;
    for (int i = 0; i < 4; i++) begin
      v = 8'($urandom_range(0, 255));
      run_conv(v, -1, "random");
    end
  endtask

  task automatic test_start_ignored();
    run_conv(8'h6E, 50, "start_busy");
  endtask

  task automatic test_back_to_back();
    int nvalid;
    int vc [2];
    logic [7:0] res [2];
    int drop_at;
    vin_code = 8'h3C;
    nvalid = 0;
    drop_at = -1;
    vc[0] = -1; vc[1] = -1;
    res[0] = 8'h00; res[1] = 8'h00;
    @(negedge clk); cont = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3 * PERIOD; k++) begin
      if (result_valid === 1'b1) begin
        if (nvalid < 2) begin
          vc[nvalid] = k;
          res[nvalid] = result;
        end
        nvalid++;
        if (nvalid == 1) begin
          vin_code = 8'hC3;
          drop_at = k + 30;
        end
      end
      if (k == drop_at) cont = 1'b0;
      @(negedge clk);
    end
    cont = 1'b0;
    checks++; if (nvalid !== 2) begin errors++; $display("FAIL cont_valid_count got %0d exp 2", nvalid); end
    checks++; if (res[0] !== 8'h3C) begin errors++; $display("FAIL cont_result0 got %h exp 3c", res[0]); end
    checks++; if (res[1] !== 8'hC3) begin errors++; $display("FAIL cont_result1 got %h exp c3", res[1]); end
    checks++; if (vc[0] !== LAT) begin errors++; $display("FAIL cont_first_latency got %0d exp %0d", vc[0], LAT); end
    checks++; if (vc[1] - vc[0] !== PERIOD) begin errors++; $display("FAIL cont_period got %0d exp %0d", vc[1] - vc[0], PERIOD); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL cont_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_reset_mid();
    int nvalid;
    int nbusy;
    vin_code = 8'h77;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (70) @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++; if (dac_bin !== 8'h00) begin errors++; $display("FAIL rstmid_dac_bin got %h exp 00", dac_bin); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", busy); end
    checks++; if (result !== 8'h00) begin errors++; $display("FAIL rstmid_result got %h exp 00", result); end
    checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", result_valid); end
    checks++; if (led !== 8'h00) begin errors++; $display("FAIL rstmid_led got %h exp 00", led); end
    @(negedge clk);
    rstn = 1'b1;
    nvalid = 0;
    nbusy = 0;
    for (int k = 0; k < LAT + 20; k++) begin
      @(negedge clk);
      if (result_valid === 1'b1) nvalid++;
      if (busy !== 1'b0) nbusy++;
    end
    checks++; if (nvalid !== 0) begin errors++; $display("FAIL rstmid_no_valid got %0d exp 0", nvalid); end
    checks++; if (nbusy !== 0) begin errors++; $display("FAIL rstmid_busy_after got %0d exp 0", nbusy); end
    run_conv(8'h5A, -1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_boundaries();
    test_start_ignored();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
